// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 32x32 register file, forwarding, load-use
// interlock and branch resolution feeding the EX stage.
module id_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         IF_to_ID_Valid,
    input  logic [63:0]  IF_to_ID_Bus,
    output logic         ID_Allow_in,
    output logic [33:0]  br_bus,
    input  logic         EX_Allow_in,
    output logic         ID_to_EX_Valid,
    output logic [147:0] ID_to_EX_Bus,
    input  logic [39:0]  EX_fwd_bus,
    input  logic [38:0]  MEM_fwd_bus,
    input  logic         WB_rf_we,
    input  logic [4:0]   WB_rf_waddr,
    input  logic [31:0]  WB_rf_wdata
);

    logic        id_valid;
    logic [31:0] id_pc, id_inst;
    logic        load_use, ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_pc    <= 32'd0;
            id_inst  <= 32'd0;
        end else if (ID_Allow_in) begin
            id_valid <= IF_to_ID_Valid;
            id_pc    <= IF_to_ID_Bus[63:32];
            id_inst  <= IF_to_ID_Bus[31:0];
        end
    end

    // Register file carries no reset; r0 is forced to zero on read instead.
    logic [31:0] rf [32];
    always_ff @(posedge clk) begin
        if (WB_rf_we && WB_rf_waddr != 5'd0)
            rf[WB_rf_waddr] <= WB_rf_wdata;
    end

    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [5:0]  op6;
    logic [4:0]  rj, rk, rd, r2, dest;
    assign op17 = id_inst[31:15];
    assign op10 = id_inst[31:22];
    assign op7  = id_inst[31:25];
    assign op6  = id_inst[31:26];
    assign rj   = id_inst[9:5];
    assign rk   = id_inst[14:10];
    assign rd   = id_inst[4:0];

    logic is_add, is_sub, is_slt, is_sltu, is_nor, is_and, is_or, is_xor;
    logic is_addi, is_ld, is_st, is_lu12i, is_jirl, is_b, is_bl, is_beq, is_bne;
    logic is_rtype, is_branch, uses_rj, uses_r2, src_is_rd, gr_we, link;
    assign is_add   = op17 == 17'h00020;
    assign is_sub   = op17 == 17'h00022;
    assign is_slt   = op17 == 17'h00024;
    assign is_sltu  = op17 == 17'h00025;
    assign is_nor   = op17 == 17'h00028;
    assign is_and   = op17 == 17'h00029;
    assign is_or    = op17 == 17'h0002a;
    assign is_xor   = op17 == 17'h0002b;
    assign is_addi  = op10 == 10'h00a;
    assign is_ld    = op10 == 10'h0a2;
    assign is_st    = op10 == 10'h0a6;
    assign is_lu12i = op7  == 7'h0a;
    assign is_jirl  = op6  == 6'h13;
    assign is_b     = op6  == 6'h14;
    assign is_bl    = op6  == 6'h15;
    assign is_beq   = op6  == 6'h16;
    assign is_bne   = op6  == 6'h17;

    assign is_rtype  = is_add | is_sub | is_slt | is_sltu | is_nor | is_and | is_or | is_xor;
    assign is_branch = is_jirl | is_b | is_bl | is_beq | is_bne;
    assign src_is_rd = is_st | is_beq | is_bne;
    assign uses_rj   = is_rtype | is_addi | is_ld | is_st | is_jirl | is_beq | is_bne;
    assign uses_r2   = is_rtype | src_is_rd;
    assign link      = is_jirl | is_bl;
    assign r2        = src_is_rd ? rd : rk;
    assign dest      = is_bl ? 5'd1 : rd;
    assign gr_we     = (is_rtype | is_addi | is_ld | is_lu12i | link) & (dest != 5'd0);

    logic [11:0] alu_op;
    assign alu_op = {is_lu12i, 3'b000, is_xor, is_or, is_nor, is_and,
                     is_sltu, is_slt, is_sub,
                     is_add | is_addi | is_ld | is_st | link};

    logic [31:0] si12, lu12i_imm, offs16, offs26;
    assign si12      = {{20{id_inst[21]}}, id_inst[21:10]};
    assign lu12i_imm = {id_inst[24:5], 12'b0};
    assign offs16    = {{14{id_inst[25]}}, id_inst[25:10], 2'b00};
    assign offs26    = {{4{id_inst[9]}}, id_inst[9:0], id_inst[25:10], 2'b00};

    logic        ex_valid, ex_gr_we, ex_is_load, mem_valid, mem_gr_we;
    logic [4:0]  ex_dest, mem_dest;
    logic [31:0] ex_result, mem_result;
    assign {ex_valid, ex_gr_we, ex_is_load, ex_dest, ex_result} = EX_fwd_bus;
    assign {mem_valid, mem_gr_we, mem_dest, mem_result}         = MEM_fwd_bus;

    // Youngest producer wins: EX, then MEM, then the WB write port, then the file.
    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (r == 5'd0)                                  return 32'd0;
        else if (ex_valid && ex_gr_we && ex_dest == r)  return ex_result;
        else if (mem_valid && mem_gr_we && mem_dest == r) return mem_result;
        else if (WB_rf_we && WB_rf_waddr == r)          return WB_rf_wdata;
        else                                            return rf[r];
    endfunction

    logic [31:0] rj_val, r2_val, src1, src2, br_target;
    logic        cond, br_taken, br_stall;
    assign rj_val = fwd(rj);
    assign r2_val = fwd(r2);

    assign load_use = id_valid & ex_valid & ex_is_load & (ex_dest != 5'd0)
                    & ((uses_rj & ex_dest == rj) | (uses_r2 & ex_dest == r2));
    assign ready_go       = ~load_use;
    assign ID_Allow_in    = ~id_valid | (ready_go & EX_Allow_in);
    assign ID_to_EX_Valid = id_valid & ready_go;

    assign src1 = link ? id_pc : rj_val;
    assign src2 = link                       ? 32'd4 :
                  (is_addi | is_ld | is_st)  ? si12 :
                  is_lu12i                   ? lu12i_imm : r2_val;

    assign cond = (is_beq & (rj_val == r2_val)) | (is_bne & (rj_val != r2_val))
                | is_b | is_bl | is_jirl;
    assign br_target = is_jirl         ? rj_val + offs16 :
                       (is_b | is_bl)  ? id_pc + offs26 : id_pc + offs16;
    assign br_taken  = id_valid & ready_go & EX_Allow_in & cond;
    assign br_stall  = id_valid & load_use & is_branch;
    assign br_bus    = {br_taken, br_target, br_stall};

    assign ID_to_EX_Bus = {alu_op, src1, src2, r2_val, dest, gr_we,
                           is_st, is_ld, id_pc};

endmodule
